// File: rtl/apu_fpu_arbiter.sv
// Shares one FPU among NUM_CORES APU requesters: credit-limited round-robin or fixed-priority
// issue, tag-based response routing, and a sticky flag for responses nobody is waiting for.
module apu_fpu_arbiter #(
  parameter int NUM_CORES       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5,
  parameter int IDW             = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CORES-1:0]            apu_req_i,
  output logic [NUM_CORES-1:0]            apu_gnt_o,
  input  logic [NUM_CORES*NARGS*32-1:0]   apu_operands_i,
  input  logic [NUM_CORES*WOP-1:0]        apu_op_i,
  input  logic [NUM_CORES*NDSFLAGS-1:0]   apu_flags_i,
  output logic [NUM_CORES-1:0]            apu_rvalid_o,
  output logic [NUM_CORES*32-1:0]         apu_rdata_o,
  output logic [NUM_CORES*NUSFLAGS-1:0]   apu_rflags_o,
  output logic                            fpu_in_valid_o,
  input  logic                            fpu_in_ready_i,
  output logic [NARGS*32-1:0]             fpu_operands_o,
  output logic [WOP-1:0]                  fpu_op_o,
  output logic [NDSFLAGS-1:0]             fpu_flags_o,
  output logic [IDW-1:0]                  fpu_tag_o,
  input  logic                            fpu_out_valid_i,
  output logic                            fpu_out_ready_o,
  input  logic [31:0]                     fpu_result_i,
  input  logic [NUSFLAGS-1:0]             fpu_status_i,
  input  logic [IDW-1:0]                  fpu_tag_i,
  output logic                            orphan_err_o
);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int OPW = NARGS * 32;

  logic [CW-1:0]        total_reg;
  logic [CW-1:0]        outstanding_reg [NUM_CORES];
  logic [IDW-1:0]       rr_ptr_reg;
  logic                 orphan_reg;

  logic                 credit_ok;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] at_or_after_ptr;
  logic [NUM_CORES-1:0] upper_req;
  logic [NUM_CORES-1:0] req_sel;
  logic [NUM_CORES-1:0] win_onehot;
  logic [NUM_CORES-1:0] tag_hit;
  logic [NUM_CORES-1:0] cnt_nz;
  logic [IDW-1:0]       win_idx;
  logic [IDW-1:0]       rr_next;
  logic                 issue;
  logic                 resp_fire;
  logic                 retire;
  logic                 orphan_hit;

  assign credit_ok = (total_reg < CW'(MAX_OUTSTANDING));
  assign eligible  = rst_i ? '0 : (apu_req_i & {NUM_CORES{credit_ok}});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign at_or_after_ptr[gi] = (IDW'(gi) >= rr_ptr_reg);
      assign tag_hit[gi]         = (fpu_tag_i == IDW'(gi));
      assign cnt_nz[gi]          = (outstanding_reg[gi] != '0);
    end
  endgenerate

  // Round-robin: prefer requesters at/after the pointer, otherwise wrap to the lowest index.
  assign upper_req  = eligible & at_or_after_ptr;
  assign req_sel    = (ARB_MODE == 0 && upper_req != '0) ? upper_req : eligible;
  assign win_onehot = req_sel & (~req_sel + NUM_CORES'(1));

  always_comb begin
    win_idx        = '0;
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (win_onehot[j]) begin
        win_idx        = IDW'(j);
        fpu_operands_o = apu_operands_i[j*OPW +: OPW];
        fpu_op_o       = apu_op_i[j*WOP +: WOP];
        fpu_flags_o    = apu_flags_i[j*NDSFLAGS +: NDSFLAGS];
      end
    end
  end

  assign fpu_tag_o       = win_idx;
  assign fpu_in_valid_o  = |eligible;
  assign issue           = fpu_in_valid_o & fpu_in_ready_i;
  assign apu_gnt_o       = issue ? win_onehot : '0;
  assign rr_next         = (win_idx == IDW'(NUM_CORES - 1)) ? '0 : win_idx + IDW'(1);

  assign fpu_out_ready_o = ~rst_i;
  assign resp_fire       = fpu_out_valid_i & fpu_out_ready_o;
  // An out-of-range tag matches no core, so it falls through to the orphan path.
  assign retire          = resp_fire & (|(tag_hit & cnt_nz));
  assign orphan_hit      = resp_fire & ~retire;
  assign orphan_err_o    = orphan_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_reg    <= '0;
      rr_ptr_reg   <= '0;
      orphan_reg   <= 1'b0;
      apu_rvalid_o <= '0;
      apu_rdata_o  <= '0;
      apu_rflags_o <= '0;
      for (int j = 0; j < NUM_CORES; j++) begin
        outstanding_reg[j] <= '0;
      end
    end else begin
      if (issue && !retire) begin
        total_reg <= total_reg + CW'(1);
      end else if (!issue && retire) begin
        total_reg <= total_reg - CW'(1);
      end
      if (issue) begin
        rr_ptr_reg <= rr_next;
      end
      if (orphan_hit) begin
        orphan_reg <= 1'b1;
      end
      for (int j = 0; j < NUM_CORES; j++) begin
        if (issue && win_onehot[j] && !(retire && tag_hit[j])) begin
          outstanding_reg[j] <= outstanding_reg[j] + CW'(1);
        end else if (retire && tag_hit[j] && !(issue && win_onehot[j])) begin
          outstanding_reg[j] <= outstanding_reg[j] - CW'(1);
        end
        apu_rvalid_o[j] <= retire && tag_hit[j];
        if (retire && tag_hit[j]) begin
          apu_rdata_o[j*32 +: 32]             <= fpu_result_i;
          apu_rflags_o[j*NUSFLAGS +: NUSFLAGS] <= fpu_status_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_apu_fpu_arbiter.sv
// Scoreboard bench for apu_fpu_arbiter: a round-robin instance and a fixed-priority instance
// share stimulus; an independent arbitration/credit model predicts every cycle.
module tb_apu_fpu_arbiter;
  localparam int N     = 2;
  localparam int MAXO  = 4;
  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int IDW   = 1;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [N-1:0]           apu_req_i;
  logic [N*NARGS*32-1:0]  apu_operands_i;
  logic [N*WOP-1:0]       apu_op_i;
  logic [N*NDS-1:0]       apu_flags_i;
  logic                   fpu_in_ready_i;
  logic                   fpu_out_valid_i;
  logic [31:0]            fpu_result_i;
  logic [NUS-1:0]         fpu_status_i;
  logic [IDW-1:0]         fpu_tag_i;

  logic [N-1:0]           apu_gnt_o, apu_rvalid_o;
  logic [N*32-1:0]        apu_rdata_o;
  logic [N*NUS-1:0]       apu_rflags_o;
  logic                   fpu_in_valid_o, fpu_out_ready_o, orphan_err_o;
  logic [NARGS*32-1:0]    fpu_operands_o;
  logic [WOP-1:0]         fpu_op_o;
  logic [NDS-1:0]         fpu_flags_o;
  logic [IDW-1:0]         fpu_tag_o;

  logic [N-1:0]           fp_gnt, fp_rvalid;
  logic [N*32-1:0]        fp_rdata;
  logic [N*NUS-1:0]       fp_rflags;
  logic                   fp_in_valid, fp_out_ready, fp_orphan;
  logic [NARGS*32-1:0]    fp_operands;
  logic [WOP-1:0]         fp_op;
  logic [NDS-1:0]         fp_flags;
  logic [IDW-1:0]         fp_tag;

  always #5 clk_i = ~clk_i;

  apu_fpu_arbiter #(.NUM_CORES(N), .MAX_OUTSTANDING(MAXO), .ARB_MODE(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
    .apu_rvalid_o(apu_rvalid_o), .apu_rdata_o(apu_rdata_o), .apu_rflags_o(apu_rflags_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
    .fpu_tag_o(fpu_tag_o), .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .orphan_err_o(orphan_err_o)
  );

  apu_fpu_arbiter #(.NUM_CORES(N), .MAX_OUTSTANDING(MAXO), .ARB_MODE(1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .apu_req_i(apu_req_i), .apu_gnt_o(fp_gnt),
    .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
    .apu_rvalid_o(fp_rvalid), .apu_rdata_o(fp_rdata), .apu_rflags_o(fp_rflags),
    .fpu_in_valid_o(fp_in_valid), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_operands_o(fp_operands), .fpu_op_o(fp_op), .fpu_flags_o(fp_flags),
    .fpu_tag_o(fp_tag), .fpu_out_valid_i(1'b0), .fpu_out_ready_o(fp_out_ready),
    .fpu_result_i(32'h0), .fpu_status_i(5'h0), .fpu_tag_i(1'b0),
    .orphan_err_o(fp_orphan)
  );

  typedef struct {
    int          core;
    logic [31:0] data;
    logic [4:0]  flags;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_out[N];
  int   mdl_tot;
  int   mdl_ptr;
  bit   mdl_orphan;
  int   fp_tot;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WOP-1:0] op_of(input int c);
    return WOP'(17 * (c + 1));
  endfunction

  function automatic logic [NDS-1:0] flags_of(input int c);
    return NDS'(16'h1000 + c);
  endfunction

  function automatic logic [NARGS*32-1:0] ops_of(input int c);
    logic [NARGS*32-1:0] r;
    for (int a = 0; a < NARGS; a++) r[a*32 +: 32] = 32'hC0DE0000 | (c << 8) | a;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) mdl_out[c] = 0;
    mdl_tot = 0; mdl_ptr = 0; mdl_orphan = 0; fp_tot = 0;
    exp_q.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    logic [N-1:0] elig, fp_elig, exp_gnt, fp_exp_gnt;
    int   w, t;
    bit   v;
    exp_t e;
    @(negedge clk_i);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid", apu_rvalid_o, 1 << e.core);
      chk("rdata", apu_rdata_o[e.core*32 +: 32], e.data);
      chk("rflags", apu_rflags_o[e.core*NUS +: NUS], e.flags);
      $display("RSP core %0d data %h flags %h", e.core, e.data, e.flags);
    end else begin
      chk("rvalid_idle", apu_rvalid_o, 0);
    end
    chk("orphan", orphan_err_o, mdl_orphan);
    chk("out_ready", fpu_out_ready_o, 1);

    elig = (mdl_tot < MAXO) ? apu_req_i : '0;
    v = |elig;
    w = 0;
    for (int k = N - 1; k >= 0; k--) if (elig[(mdl_ptr + k) % N]) w = (mdl_ptr + k) % N;
    exp_gnt = (v && fpu_in_ready_i) ? N'(1 << w) : '0;
    chk("in_valid", fpu_in_valid_o, v);
    chk("gnt", apu_gnt_o, exp_gnt);
    if (v) begin
      chk("tag", fpu_tag_o, w);
      chk("op", fpu_op_o, op_of(w));
      chk("operands", fpu_operands_o, ops_of(w));
      chk("flags", fpu_flags_o, flags_of(w));
    end

    fp_elig = (fp_tot < MAXO) ? apu_req_i : '0;
    fp_exp_gnt = '0;
    for (int k = N - 1; k >= 0; k--) if (fp_elig[k]) fp_exp_gnt = N'(1 << k);
    if (!fpu_in_ready_i) fp_exp_gnt = '0;
    chk("fp_gnt", fp_gnt, fp_exp_gnt);
    chk("fp_in_valid", fp_in_valid, |fp_elig);

    // Response decision uses the counts from before this cycle's issue.
    if (fpu_out_valid_i) begin
      t = int'(fpu_tag_i);
      if (mdl_out[t] > 0) begin
        mdl_out[t]--; mdl_tot--;
        e.core = t; e.data = fpu_result_i; e.flags = fpu_status_i;
        exp_q.push_back(e);
      end else begin
        mdl_orphan = 1;
        $display("ORPHAN response tag %0d", t);
      end
    end
    if (exp_gnt != '0) begin
      mdl_out[w]++; mdl_tot++; mdl_ptr = (w + 1) % N;
      $display("GNT core %0d op %h", w, op_of(w));
    end
    if (fp_exp_gnt != '0) fp_tot++;
    @(posedge clk_i); #1;
  endtask

  task automatic resp(input int t, input logic [31:0] d, input logic [4:0] s);
    fpu_out_valid_i = 1'b1; fpu_tag_i = IDW'(t); fpu_result_i = d; fpu_status_i = s;
    cycle();
    fpu_out_valid_i = 1'b0;
  endtask

  task automatic check_reset();
    @(negedge clk_i);
    chk("rst_gnt", apu_gnt_o, 0);
    chk("rst_in_valid", fpu_in_valid_o, 0);
    chk("rst_rvalid", apu_rvalid_o, 0);
    chk("rst_rdata", apu_rdata_o, 0);
    chk("rst_rflags", apu_rflags_o, 0);
    chk("rst_out_ready", fpu_out_ready_o, 0);
    chk("rst_orphan", orphan_err_o, 0);
    chk("rst_fp_gnt", fp_gnt, 0);
    chk("rst_fp_in_valid", fp_in_valid, 0);
    $display("RST checked");
    model_reset();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; apu_req_i = '0; fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b0;
    fpu_tag_i = '0; fpu_result_i = '0; fpu_status_i = '0;
    for (int c = 0; c < N; c++) begin
      apu_op_i[c*WOP +: WOP]                   = op_of(c);
      apu_flags_i[c*NDS +: NDS]                = flags_of(c);
      apu_operands_i[c*NARGS*32 +: NARGS*32]   = ops_of(c);
    end
    model_reset();
    @(posedge clk_i); #1;
    apu_req_i = 2'b11;
    check_reset();
    rst_i = 1'b0;

    // Alternating grants, then credit exhaustion at four in flight.
    repeat (6) cycle();
    resp(1, 32'h3F800000, 5'h01);
    cycle();
    cycle();
    // Retire core 0 at full credit, then issue and retire together at a count of three.
    resp(0, $urandom, 5'($urandom));
    resp(1, $urandom, 5'($urandom));
    cycle();
    cycle();

    apu_req_i = '0;
    for (int i = 0; i < 20 && mdl_tot > 0; i++) begin
      int t;
      t = (mdl_out[0] > 0) ? 0 : 1;
      resp(t, $urandom, 5'($urandom));
    end
    cycle();

    resp(0, 32'hDEAD0000, 5'h1F);
    repeat (3) cycle();

    for (int i = 0; i < 150; i++) begin
      int t;
      apu_req_i = N'($urandom);
      fpu_in_ready_i = ($urandom_range(0, 3) != 0);
      t = $urandom_range(0, N - 1);
      if (mdl_out[t] > 0 && $urandom_range(0, 1) == 1) begin
        fpu_out_valid_i = 1'b1; fpu_tag_i = IDW'(t);
        fpu_result_i = $urandom; fpu_status_i = 5'($urandom);
      end
      cycle();
      fpu_out_valid_i = 1'b0;
    end

    apu_req_i = 2'b11; fpu_in_ready_i = 1'b1;
    rst_i = 1'b1;
    check_reset();
    rst_i = 1'b0;
    repeat (5) cycle();
    apu_req_i = '0;
    resp(0, 32'h12345678, 5'h02);
    resp(1, 32'h12345679, 5'h03);
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apu_fpu_arbiter.md
APU_FPU_ARBITER -- requirements
Module: apu_fpu_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of APU requester channels (1..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, global cap on in-flight FPU operations (1..15).
REQ-003 SHALL have parameter ARB_MODE, default 0, arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-004 SHALL have parameters NARGS=3, WOP=6, NDSFLAGS=15, NUSFLAGS=5, giving the APU operand count, op width, downstream flag width and upstream flag width.
REQ-005 SHALL derive IDW = max(1, clog2(NUM_CORES)) as the tag width.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 apu_req_i  in  NUM_CORES  per-core request valid.
REQ-009 apu_gnt_o  out  NUM_CORES  per-core grant (accept).
REQ-010 apu_operands_i  in  NUM_CORES x NARGS x 32  per-core operands.
REQ-011 apu_op_i  in  NUM_CORES x WOP  per-core opcode.
REQ-012 apu_flags_i  in  NUM_CORES x NDSFLAGS  per-core format and rounding flags.
REQ-013 apu_rvalid_o  out  NUM_CORES  per-core result valid, one-cycle pulse.
REQ-014 apu_rdata_o  out  NUM_CORES x 32  per-core result.
REQ-015 apu_rflags_o  out  NUM_CORES x NUSFLAGS  per-core status flags.
REQ-016 fpu_in_valid_o / fpu_in_ready_i  out/in  1/1  FPU request handshake.
REQ-017 fpu_operands_o, fpu_op_o, fpu_flags_o  out  NARGS x 32, WOP, NDSFLAGS  muxed payload of the granted core.
REQ-018 fpu_tag_o  out  IDW  index of the granted core.
REQ-019 fpu_out_valid_i / fpu_out_ready_o  in/out  1/1  FPU response handshake.
REQ-020 fpu_result_i, fpu_status_i, fpu_tag_i  in  32, NUSFLAGS, IDW  FPU response payload.
REQ-021 orphan_err_o  out  1  sticky error flag: response arrived for a core with zero outstanding operations.

Function
REQ-022 Credit rule: credit_ok = (total_outstanding < MAX_OUTSTANDING).
REQ-023 Eligible set: apu_req_i masked by credit_ok; no grant of any kind is issued while credit_ok=0.
REQ-024 Round-robin (ARB_MODE=0): winner = first eligible index at or after rr_ptr, searching with wrap-around modulo NUM_CORES.
REQ-025 Fixed priority (ARB_MODE=1): winner = lowest eligible index; rr_ptr is unused.
REQ-026 fpu_in_valid_o = any eligible; payload and fpu_tag_o come from the winner, combinationally, in the same cycle.
REQ-027 apu_gnt_o[winner] = fpu_in_valid_o & fpu_in_ready_i; all other grant bits are 0; at most one bit is set.
REQ-028 On handshake, rr_ptr <= (winner+1) mod NUM_CORES; rr_ptr is unchanged when there is no handshake.
REQ-029 fpu_out_ready_o SHALL be held at 1 whenever rst_i=0.
REQ-030 Issue increments total_outstanding and outstanding[winner]; a response retire decrements total_outstanding and outstanding[fpu_tag_i].
REQ-031 When issue and retire occur in the same cycle, total_outstanding is unchanged, and per-core counters update independently (same core: unchanged).
REQ-032 Response latency: apu_rvalid_o[fpu_tag_i] pulses exactly one cycle after fpu_out_valid_i=1; apu_rdata_o and apu_rflags_o of that core are registered with that response.
REQ-033 apu_rdata_o and apu_rflags_o hold their last values when rvalid is low; other cores' outputs are unaffected.
REQ-034 Responses with fpu_tag_i >= NUM_CORES, or targeting a core whose outstanding count is 0, SHALL set orphan_err_o, produce no rvalid and leave all counters unchanged.
REQ-035 Counters never wrap: total_outstanding saturates at MAX_OUTSTANDING by construction (REQ-023) and never goes below 0 (REQ-034).

Reset
REQ-036 While rst_i=1: apu_gnt_o=0, apu_rvalid_o=0, apu_rdata_o=0, apu_rflags_o=0, fpu_in_valid_o=0, fpu_out_ready_o=0, rr_ptr=0, all outstanding counters=0, orphan_err_o=0.
REQ-037 Reset asserted mid-operation discards all in-flight bookkeeping; FPU responses after reset release with no outstanding operations are treated as orphans (REQ-034).

Verification
REQ-038 Scenario: NUM_CORES=2, ARB_MODE=0, both cores requesting every cycle, fpu_in_ready_i=1 -> grants alternate 0,1,0,1; fpu_tag_o follows 0,1,0,1.
REQ-039 Scenario: MAX_OUTSTANDING=4, no responses returned -> exactly 4 grants issued, then fpu_in_valid_o=0 until one response arrives, after which one further grant is issued.
REQ-040 Scenario: response with tag=1, result=0x3F800000, status=5'h01 -> the next cycle shows apu_rvalid_o=2'b10, apu_rdata_o[1]=0x3F800000, apu_rflags_o[1]=0x01.
REQ-041 Scenario: counter at 3 with issue and retire in the same cycle -> counter remains 3 and both the grant and the rvalid occur.
REQ-042 Scenario: response tag=0 while outstanding[0]=0 -> orphan_err_o=1 persists until reset and no rvalid is produced.
REQ-043 Scenario: ARB_MODE=1, cores 0 and 1 both requesting continuously -> only core 0 is granted; rst_i pulsed mid-run -> all outputs return to the zero values of REQ-036.
